// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one ram512x8 port between instruction fetch
// and data access with round-robin grants, MFC timeout and alignment checks.
module ram_access_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  input  logic              dataReq,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic              dataRW,
  input  logic [1:0]        dataSize,
  input  logic              ramMFC,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [1:0]        ramDataSize,
  output logic              fetchDone,
  output logic              dataDone,
  output logic              irLoad,
  output logic              mdrLoad,
  output logic              busError,
  output logic [1:0]        errCode
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE,
    ERROR
  } state_t;

  localparam logic FETCH = 1'b1;
  localparam logic DATA  = 1'b0;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_TIME  = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  localparam logic [8:0] LIMIT = 9'(TIMEOUT);

  state_t state;
  state_t state_n;

  logic owner;
  logic owner_n;
  logic last_owner;
  logic last_owner_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;

  logic [ADDR_W-1:0] addr_n;
  logic              rw_n;
  logic [1:0]        size_n;
  logic [1:0]        err_n;

  logic mfa_n;
  logic fdone_n;
  logic ddone_n;
  logic ir_n;
  logic mdr_n;
  logic berr_n;

  logic              grant_any;
  logic              grant_fetch;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [1:0]        req_size;
  logic              misaligned;
  logic              cnt_hit;

  assign grant_any = fetchReq | dataReq;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_fetch = 1'b0;
    unique case (1'b1)
      fetchReq && dataReq:  grant_fetch = (last_owner != FETCH);
      fetchReq && !dataReq: grant_fetch = 1'b1;
      default:              grant_fetch = 1'b0;
    endcase
  end

  always_comb begin
    req_addr = grant_fetch ? fetchAddr : dataAddr;
    req_rw   = grant_fetch | dataRW;
    req_size = dataSize;
    if (grant_fetch || dataSize == 2'b11) begin
      req_size = SZ_WORD;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      SZ_WORD: misaligned = |req_addr[1:0];
      SZ_HALF: misaligned = req_addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  // Last ACCESS cycle allowed before the timeout fires.
  assign cnt_hit = ({1'b0, cnt} + 9'd1) == LIMIT;

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    cnt_n        = cnt;
    addr_n       = ramAddress;
    rw_n         = ramRW;
    size_n       = ramDataSize;
    err_n        = errCode;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          owner_n      = grant_fetch;
          last_owner_n = grant_fetch;
          addr_n       = req_addr;
          rw_n         = req_rw;
          size_n       = req_size;
          cnt_n        = 8'd0;
          if (misaligned) begin
            state_n = ERROR;
            err_n   = ERR_ALIGN;
          end else begin
            state_n = ACCESS;
            err_n   = ERR_NONE;
          end
        end
      end
      ACCESS: begin
        cnt_n = cnt + 8'd1;
        if (ramMFC) begin
          state_n = RELEASE;
        end else if (cnt_hit) begin
          state_n = ERROR;
          err_n   = ERR_TIME;
        end
      end
      RELEASE: state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output flops are loaded with the values of the state being entered.
  always_comb begin
    mfa_n   = (state_n == ACCESS);
    fdone_n = 1'b0;
    ddone_n = 1'b0;
    ir_n    = 1'b0;
    mdr_n   = 1'b0;
    berr_n  = 1'b0;
    if (state_n == RELEASE || state_n == ERROR) begin
      fdone_n = (owner_n == FETCH);
      ddone_n = (owner_n == DATA);
    end
    if (state_n == RELEASE) begin
      ir_n  = (owner_n == FETCH);
      mdr_n = (owner_n == DATA) && rw_n;
    end
    if (state_n == ERROR) begin
      berr_n = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= DATA;
      last_owner  <= DATA;
      cnt         <= 8'd0;
      ramMFA      <= 1'b0;
      ramRW       <= 1'b0;
      ramAddress  <= '0;
      ramDataSize <= 2'b00;
      fetchDone   <= 1'b0;
      dataDone    <= 1'b0;
      irLoad      <= 1'b0;
      mdrLoad     <= 1'b0;
      busError    <= 1'b0;
      errCode     <= ERR_NONE;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last_owner  <= last_owner_n;
      cnt         <= cnt_n;
      ramMFA      <= mfa_n;
      ramRW       <= rw_n;
      ramAddress  <= addr_n;
      ramDataSize <= size_n;
      fetchDone   <= fdone_n;
      dataDone    <= ddone_n;
      irLoad      <= ir_n;
      mdrLoad     <= mdr_n;
      busError    <= berr_n;
      errCode     <= err_n;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed and randomized transactions checked
// against a transaction-level model of grant order, latency and errors.
module tb_ram_access_arbiter;

  localparam int TIMEOUT = 15;

  logic       Clk = 1'b0;
  logic       reset;
  logic       fetchReq;
  logic [8:0] fetchAddr;
  logic       dataReq;
  logic [8:0] dataAddr;
  logic       dataRW;
  logic [1:0] dataSize;
  logic       ramMFC;
  logic       ramMFA;
  logic       ramRW;
  logic [8:0] ramAddress;
  logic [1:0] ramDataSize;
  logic       fetchDone;
  logic       dataDone;
  logic       irLoad;
  logic       mdrLoad;
  logic       busError;
  logic [1:0] errCode;

  int n_checks = 0;
  int n_errors = 0;
  bit last_f   = 1'b0;

  ram_access_arbiter #(
    .ADDR_W  (9),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .fetchReq    (fetchReq),
    .fetchAddr   (fetchAddr),
    .dataReq     (dataReq),
    .dataAddr    (dataAddr),
    .dataRW      (dataRW),
    .dataSize    (dataSize),
    .ramMFC      (ramMFC),
    .ramMFA      (ramMFA),
    .ramRW       (ramRW),
    .ramAddress  (ramAddress),
    .ramDataSize (ramDataSize),
    .fetchDone   (fetchDone),
    .dataDone    (dataDone),
    .irLoad      (irLoad),
    .mdrLoad     (mdrLoad),
    .busError    (busError),
    .errCode     (errCode)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    fetchReq = 1'b0;
    dataReq  = 1'b0;
    ramMFC   = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_out", 32'({ramMFA, ramRW, ramDataSize, ramAddress,
          fetchDone, dataDone, irLoad, mdrLoad, busError, errCode}), 32'd0);
    reset  = 1'b0;
    last_f = 1'b0;
  endtask

  // Called at the falling edge of an IDLE cycle with requests already set.
  // mfc_at: ACCESS cycle (1-based) in which MFC is returned; 0 or beyond
  // TIMEOUT means never.
  task automatic txn(input int mfc_at, input bit scramble);
    bit         own_f;
    bit         mis;
    bit         ok;
    int         a;
    int         n_acc;
    logic [8:0] ea;
    logic       erw;
    logic [1:0] esz;
    logic [1:0] eerr;
    own_f  = (fetchReq && dataReq) ? !last_f : fetchReq;
    last_f = own_f;
    ea     = own_f ? fetchAddr : dataAddr;
    a      = int'(ea);
    erw    = own_f ? 1'b1 : dataRW;
    esz    = own_f ? 2'd2 : ((dataSize == 2'd3) ? 2'd2 : dataSize);
    mis    = (esz == 2'd2 && a % 4 != 0) || (esz == 2'd1 && a % 2 != 0);
    if (mis) begin
      n_acc = 0;
      ok    = 1'b0;
      eerr  = 2'd2;
    end else if (mfc_at >= 1 && mfc_at <= TIMEOUT) begin
      n_acc = mfc_at;
      ok    = 1'b1;
      eerr  = 2'd0;
    end else begin
      n_acc = TIMEOUT;
      ok    = 1'b0;
      eerr  = 2'd1;
    end
    @(posedge Clk);
    for (int k = 1; k <= n_acc; k++) begin
      @(negedge Clk);
      check("access_bus", 32'({ramMFA, ramRW, ramDataSize, ramAddress, errCode}),
            32'({1'b1, erw, esz, ea, 2'b00}));
      check("access_quiet", 32'({fetchDone, dataDone, irLoad, mdrLoad, busError}),
            32'd0);
      ramMFC = (k == mfc_at);
      if (scramble && k == 1) begin
        if (own_f) begin
          fetchReq  = 1'b0;
          fetchAddr = 9'($urandom);
        end else begin
          dataReq  = 1'b0;
          dataAddr = 9'($urandom);
          dataRW   = 1'($urandom);
          dataSize = 2'($urandom);
        end
      end
    end
    @(negedge Clk);
    ramMFC = (mfc_at > TIMEOUT);
    check("done_cycle", 32'({ramMFA, fetchDone, dataDone, irLoad, mdrLoad,
          busError, errCode}),
          32'({1'b0, own_f, !own_f, ok && own_f, ok && !own_f && erw,
          !ok, eerr}));
    if (own_f) fetchReq = 1'b0;
    else dataReq = 1'b0;
    @(negedge Clk);
    ramMFC = 1'b0;
    check("idle_after", 32'({ramMFA, fetchDone, dataDone, irLoad, mdrLoad,
          busError, errCode}), 32'({6'b0, eerr}));
  endtask

  task automatic idle_mfc(input int n);
    fetchReq = 1'b0;
    dataReq  = 1'b0;
    ramMFC   = 1'b1;
    repeat (n) begin
      @(negedge Clk);
      check("idle_mfc", 32'({ramMFA, fetchDone, dataDone, irLoad, mdrLoad,
            busError}), 32'd0);
    end
    ramMFC = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fetchAddr = '0;
    dataAddr  = '0;
    dataRW    = 1'b0;
    dataSize  = 2'b00;
    do_reset();

    // single fetch, MFC two cycles after MFA
    fetchReq  = 1'b1;
    fetchAddr = 9'h010;
    txn(2, 1'b0);

    // contention from reset: fetch, data, fetch, data with data writes
    do_reset();
    fetchAddr = 9'h044;
    dataAddr  = 9'h080;
    dataRW    = 1'b0;
    dataSize  = 2'b10;
    for (int i = 0; i < 4; i++) begin
      fetchReq = 1'b1;
      dataReq  = 1'b1;
      txn(1, 1'b0);
    end
    fetchReq = 1'b0;
    dataReq  = 1'b0;

    // timeout then a clean fetch
    dataReq  = 1'b1;
    dataAddr = 9'h020;
    dataRW   = 1'b1;
    dataSize = 2'b10;
    txn(0, 1'b0);
    fetchReq  = 1'b1;
    fetchAddr = 9'h030;
    txn(3, 1'b0);

    // misalignment cases and an aligned byte access
    dataReq  = 1'b1;
    dataAddr = 9'h013;
    dataSize = 2'b01;
    txn(1, 1'b0);
    dataReq  = 1'b1;
    dataAddr = 9'h012;
    dataSize = 2'b10;
    txn(1, 1'b0);
    dataReq  = 1'b1;
    dataAddr = 9'h013;
    dataSize = 2'b00;
    txn(1, 1'b0);

    // reset in ACCESS cycle 3
    fetchReq  = 1'b1;
    fetchAddr = 9'h100;
    @(posedge Clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      check("pre_reset_mfa", 32'(ramMFA), 32'd1);
    end
    reset = 1'b1;
    @(negedge Clk);
    check("reset_mid", 32'({ramMFA, ramRW, ramDataSize, ramAddress,
          fetchDone, dataDone, irLoad, mdrLoad, busError, errCode}), 32'd0);
    reset    = 1'b0;
    last_f   = 1'b0;
    fetchReq = 1'b1;
    dataReq  = 1'b1;
    dataAddr = 9'h0a4;
    dataRW   = 1'b1;
    dataSize = 2'b10;
    txn(1, 1'b0);
    txn(2, 1'b0);

    // MFC on the last allowed cycle wins; one cycle later times out
    fetchReq  = 1'b1;
    fetchAddr = 9'h0c0;
    txn(TIMEOUT, 1'b0);
    fetchReq = 1'b1;
    txn(TIMEOUT + 1, 1'b0);

    idle_mfc(3);

    for (int it = 0; it < 80; it++) begin
      if (!fetchReq) begin
        fetchAddr = 9'($urandom);
        if ($urandom_range(0, 2) != 0) fetchAddr[1:0] = 2'b00;
      end
      if (!dataReq) begin
        dataAddr = 9'($urandom);
        dataRW   = 1'($urandom);
        dataSize = 2'($urandom);
        if ($urandom_range(0, 1) != 0) dataAddr[1:0] = 2'b00;
      end
      fetchReq = fetchReq | 1'($urandom);
      dataReq  = dataReq | 1'($urandom);
      if (!fetchReq && !dataReq) fetchReq = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        txn(int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom));
      end else begin
        txn(int'($urandom_range(1, 4)), 1'($urandom));
      end
    end
    fetchReq = 1'b0;
    dataReq  = 1'b0;
    @(negedge Clk);
    check("final_idle", 32'({ramMFA, fetchDone, dataDone, irLoad, mdrLoad,
          busError}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Sequences every RAM transaction of the datapath: the MFA/MFC handshake, address, RW and dataSize to ram512x8.
- Shares the single RAM port between two requesters: instruction fetch (PC path, loads IR) and data access (MAR/MDR path, loads MDR).
- Round-robin arbitration, per-access MFC timeout and alignment checking.
- The control unit raises requests and waits for done pulses; it no longer drives RAM handshake pins directly.

Parameters:
- ADDR_W, 9, RAM address width.
- TIMEOUT, 15, max cycles in ACCESS waiting for MFC before bus error (1..255).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetchReq  input  1  fetch request; held high until fetchDone.
- fetchAddr  input  ADDR_W  fetch address; always word read.
- dataReq  input  1  data request; held high until dataDone.
- dataAddr  input  ADDR_W  data address.
- dataRW  input  1  1 = read, 0 = write.
- dataSize  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- ramMFC  input  1  memory function complete from RAM.
- ramMFA  output  1  memory function active to RAM.
- ramRW  output  1  to RAM; 1 = read.
- ramAddress  output  ADDR_W  to RAM address.
- ramDataSize  output  2  to RAM dataSize.
- fetchDone  output  1  one-cycle pulse: fetch finished (ok or error).
- dataDone  output  1  one-cycle pulse: data access finished.
- irLoad  output  1  one-cycle IR load enable on successful fetch.
- mdrLoad  output  1  one-cycle MDR load enable on successful data read.
- busError  output  1  one-cycle pulse with the done pulse on timeout or misalignment.
- errCode  output  2  00 none, 01 timeout, 10 misaligned; held until next grant.

Behaviour:
- Reset (sync, any state, incl. mid-access):
  - State IDLE; all outputs 0 (ramRW=0, ramAddress=0, ramDataSize=00).
  - Cycle counter 0; lastOwner=data, so fetch wins the first tie.
- All outputs are registered. States: IDLE, ACCESS, RELEASE, ERROR.
- IDLE:
  - At the clock edge, if fetchReq or dataReq is high, select owner:
    - Only one request high: that requester.
    - Both high: the requester that is not lastOwner.
  - Latch owner into lastOwner. Latch address, RW and size: fetch forces RW=1, size=10.
  - Alignment check:
    - Word requires addr[1:0]=00; halfword requires addr[0]=0.
    - Misaligned: go to ERROR with errCode=10; ramMFA never rises.
    - Aligned: go to ACCESS, clear counter, errCode=00.
  - ramMFC high while in IDLE is ignored.
- ACCESS:
  - ramMFA=1; ramAddress, ramRW, ramDataSize held stable for the whole state.
  - Counter increments every cycle.
  - MFC sampled high → RELEASE. If MFC and counter==TIMEOUT coincide, MFC wins.
  - Counter reaches TIMEOUT with no MFC → ERROR, errCode=01.
  - Request inputs are not re-sampled here; deasserting a req mid-access does not abort.
- RELEASE (one cycle):
  - ramMFA=0.
  - Owner's done pulse=1.
  - irLoad=1 if owner=fetch; mdrLoad=1 if owner=data and RW=1; writes pulse no load.
  - Next state IDLE.
- ERROR (one cycle):
  - ramMFA=0, owner's done=1, busError=1, no irLoad/mdrLoad.
  - Next state IDLE.
- Latency:
  - Request sampled at edge E: ramMFA high in cycle E+1.
  - MFC sampled at edge F: done pulse in cycle F+1, back in IDLE at F+2.
  - Minimum transaction 3 cycles (request edge to IDLE), MFC returned on first ACCESS cycle.
- Requesters drop req on the edge ending the done cycle. A req still high in IDLE is treated as a new request.
- Starvation-free: with both requests continuously re-raised, grants strictly alternate.
- Only one done pulse per transaction. fetchDone and dataDone are never high together.

Test Plan:
- Single fetch: fetchReq=1, fetchAddr=0x010, MFC returned 2 cycles after MFA → ramMFA high exactly 2 cycles, ramAddress=0x010, ramRW=1, ramDataSize=10; fetchDone and irLoad pulse once; busError=0.
- Contention: fetchReq and dataReq both high from reset, each re-raised after done, MFC after 1 cycle → grant order fetch, data, fetch, data; dataRW=0 transactions give dataDone with mdrLoad=0.
- Timeout: dataReq read at 0x020, MFC held low → ramMFA high for TIMEOUT=15 cycles, then dataDone+busError pulse, errCode=01, mdrLoad=0; a following fetch succeeds with errCode cleared to 00.
- Misalignment: dataReq halfword at 0x013 → no ramMFA, ERROR next cycle, dataDone+busError, errCode=10; word at 0x012 → same; byte at 0x013 → normal access.
- Reset mid-access: assert reset during ACCESS cycle 3 → next cycle ramMFA=0, all pulses 0, IDLE; subsequent simultaneous requests grant fetch first.
- MFC/timeout tie: MFC asserted on the cycle the counter hits TIMEOUT → successful RELEASE (irLoad=1), busError=0.
